// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch input path: channel indices and
// debounce defaults used by the conditioner and its per-channel debouncers.
package stopwatch_pkg;

  localparam int CH_RST   = 0;
  localparam int CH_PAUSE = 1;
  localparam int CH_ADJ   = 2;
  localparam int CH_SEL   = 3;
  localparam int NUM_CH   = 4;

  localparam int DEFAULT_STABLE_COUNT = 4;

  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: synchroniser chain, strobe-sampled debounce counter,
// stable level register and a registered rising-edge pulse.
module debounce_channel
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int CNT_W        = $clog2(STABLE_COUNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw,
  output logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   level_d;

  assign sync_q  = sync[SYNC_STAGES-1];
  assign cnt_inc = cnt + CNT_W'(1);

  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], raw};
      level_d <= level;
      pulse   <= level & ~level_d;
      if (sample_en) begin
        if (sync_q == level) begin
          cnt <= '0;
        end else if (cnt_inc == CNT_W'(STABLE_COUNT)) begin
          level <= sync_q;
          cnt   <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions the four stopwatch pins and keeps the run/pause state that
// toggles on each debounced pause press; reset press forces pause.
module input_conditioner
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int CNT_W        = $clog2(STABLE_COUNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic btn_rst_raw,
  input  logic btn_pause_raw,
  input  logic sw_adj_raw,
  input  logic sw_sel_raw,
  output logic rst_pulse,
  output logic pause_pulse,
  output logic running,
  output logic adj_level,
  output logic sel_level
);

  ch_vec_t raw;
  ch_vec_t stable;
  ch_vec_t pulse;
  logic    unused_sw_pulses;

  assign raw[CH_RST]   = btn_rst_raw;
  assign raw[CH_PAUSE] = btn_pause_raw;
  assign raw[CH_ADJ]   = sw_adj_raw;
  assign raw[CH_SEL]   = sw_sel_raw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_COUNT(STABLE_COUNT),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sample_en(sample_en),
      .raw      (raw[i]),
      .level    (stable[i]),
      .pulse    (pulse[i])
    );
  end

  // Switches are consumed as levels only; their edge pulses have no sink.
  assign unused_sw_pulses = pulse[CH_ADJ] ^ pulse[CH_SEL];

  always_ff @(posedge clk) begin
    if (rst || pulse[CH_RST]) begin
      running <= 1'b0;
    end else if (pulse[CH_PAUSE]) begin
      running <= ~running;
    end
  end

  assign rst_pulse   = pulse[CH_RST];
  assign pause_pulse = pulse[CH_PAUSE];
  assign adj_level   = stable[CH_ADJ];
  assign sel_level   = stable[CH_SEL];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: reset, clean press, bounce, switch
// glitch, simultaneous buttons and reset in the middle of a debounce.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst, sample_en;
  logic btn_rst_raw, btn_pause_raw, sw_adj_raw, sw_sel_raw;
  logic rst_pulse, pause_pulse, running, adj_level, sel_level;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  bit se_sparse = 1'b0;

  int obs_pc, obs_rc, obs_pfirst, obs_rfirst;
  bit obs_adj_seen;

  input_conditioner dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .btn_rst_raw  (btn_rst_raw),
    .btn_pause_raw(btn_pause_raw),
    .sw_adj_raw   (sw_adj_raw),
    .sw_sel_raw   (sw_sel_raw),
    .rst_pulse    (rst_pulse),
    .pause_pulse  (pause_pulse),
    .running      (running),
    .adj_level    (adj_level),
    .sel_level    (sel_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sample_en = se_sparse ? ((cyc % 4) == 0) : 1'b1;
  endtask

  task automatic observe(input int n);
    obs_pc = 0; obs_rc = 0; obs_pfirst = 0; obs_rfirst = 0; obs_adj_seen = 1'b0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (pause_pulse) begin
        obs_pc++;
        if (obs_pfirst == 0) obs_pfirst = i;
      end
      if (rst_pulse) begin
        obs_rc++;
        if (obs_rfirst == 0) obs_rfirst = i;
      end
      if (adj_level) obs_adj_seen = 1'b1;
    end
  endtask

  initial begin
    int bounce_pc;
    rst = 1'b1; sample_en = 1'b1;
    btn_rst_raw = 1'b1; btn_pause_raw = 1'b1; sw_adj_raw = 1'b1; sw_sel_raw = 1'b1;

    // Reset held with all pins high: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {rst_pulse, pause_pulse, running, adj_level, sel_level}, 5'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("post_reset_pulses", {rst_pulse, pause_pulse}, (i == 7) ? 2'b11 : 2'b00);
      check("post_reset_adj", adj_level, (i >= 6) ? 1 : 0);
    end
    check("post_reset_running", running, 0);
    btn_rst_raw = 1'b0; btn_pause_raw = 1'b0; sw_adj_raw = 1'b0; sw_sel_raw = 1'b0;
    observe(15);
    check("release_no_pulse", obs_pc + obs_rc, 0);
    check("release_levels", {adj_level, sel_level}, 2'b00);

    // Clean press: pulse 7 cycles after the raw edge, running one cycle later.
    btn_pause_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("press_pulse", pause_pulse, (i == 7) ? 1 : 0);
      check("press_running", running, (i >= 8) ? 1 : 0);
    end
    observe(41);
    check("held_no_repeat", obs_pc, 0);
    btn_pause_raw = 1'b0;
    observe(12);
    check("release_no_pulse2", obs_pc, 0);
    check("running_after_release", running, 1);
    btn_pause_raw = 1'b1;
    observe(12);
    check("second_press_count", obs_pc, 1);
    check("second_press_latency", obs_pfirst, 7);
    check("second_press_running", running, 0);
    btn_pause_raw = 1'b0;
    observe(12);

    // Bounce with sparse strobes: only the final steady level qualifies.
    se_sparse = 1'b1;
    bounce_pc = 0;
    for (int i = 0; i < 40; i++) begin
      btn_pause_raw = ((i / 6) % 2) == 0;
      tick();
      if (pause_pulse) bounce_pc++;
    end
    check("bounce_no_pulse", bounce_pc, 0);
    btn_pause_raw = 1'b1;
    observe(40);
    check("bounce_settled_pulse", obs_pc, 1);
    check("bounce_running", running, 1);
    btn_pause_raw = 1'b0;
    observe(40);
    check("bounce_release", obs_pc, 0);
    se_sparse = 1'b0;
    tick();

    // Switch glitch of two strobes is rejected; four strobes is accepted.
    for (int i = 1; i <= 10; i++) begin
      sw_adj_raw = (i <= 2);
      tick();
      check("adj_glitch", adj_level, 0);
    end
    obs_pc = 0;
    for (int i = 1; i <= 14; i++) begin
      sw_sel_raw = (i <= 4);
      tick();
      check("sel_four_strobes", sel_level, (i >= 6 && i <= 9) ? 1 : 0);
      if (pause_pulse || rst_pulse) obs_pc++;
    end
    check("switch_no_pulses", obs_pc, 0);
    check("switch_running_held", running, 1);

    // Both buttons together while running: both pulse, reset wins.
    btn_rst_raw = 1'b1; btn_pause_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("simul_pulses", {rst_pulse, pause_pulse}, (i == 7) ? 2'b11 : 2'b00);
      check("simul_running", running, (i < 8) ? 1 : 0);
    end
    btn_rst_raw = 1'b0; btn_pause_raw = 1'b0;
    observe(12);
    check("simul_release", obs_pc + obs_rc, 0);
    check("simul_running_final", running, 0);

    // Reset after two qualifying samples: count restarts from zero.
    btn_rst_raw = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("mid_pre_reset", rst_pulse, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    observe(12);
    check("mid_reset_count", obs_rc, 1);
    check("mid_reset_latency", obs_rfirst, 7);
    btn_rst_raw = 1'b0;
    observe(12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
